// File: rtl/rf_dump.sv
// Debug-side register file reader: walks the debug read port from FIRST_REG to LAST_REG
// and streams each captured word to a downstream consumer over valid/ready.
module rf_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  dbg_reg_ra,
    input  logic [31:0] dbg_reg_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LP_FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LP_LAST  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [4:0]  r_ra;
    logic        r_valid;
    logic [31:0] r_data;
    logic [4:0]  r_oidx;
    logic        r_last;
    logic        r_busy;
    logic        r_done;

    state_t      w_state_nxt;
    logic [4:0]  w_idx_nxt;
    logic [4:0]  w_ra_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_data_nxt;
    logic [4:0]  w_oidx_nxt;
    logic        w_last_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= LP_FIRST;
            r_ra    <= LP_FIRST;
            r_valid <= 1'b0;
            r_data  <= 32'd0;
            r_oidx  <= 5'd0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ra    <= w_ra_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_oidx  <= w_oidx_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ra_nxt    = r_ra;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_oidx_nxt  = r_oidx;
        w_last_nxt  = r_last;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = LP_FIRST;
                    w_ra_nxt    = LP_FIRST;
                end
            end
            S_FETCH: begin
                // Read address has been stable at r_idx for a full cycle.
                w_data_nxt  = dbg_reg_rd;
                w_oidx_nxt  = r_idx;
                w_last_nxt  = (r_idx == LP_LAST);
                w_valid_nxt = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_last) begin
                        w_state_nxt = S_DONE;
                        w_idx_nxt   = LP_FIRST;
                        w_ra_nxt    = LP_FIRST;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_idx_nxt   = r_idx + 5'd1;
                        w_ra_nxt    = r_idx + 5'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides any progress, including a same-cycle handshake.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_idx_nxt   = LP_FIRST;
            w_ra_nxt    = LP_FIRST;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    assign dbg_reg_ra = r_ra;
    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_idx    = r_oidx;
    assign out_last   = r_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_rf_dump.sv
// Randomized bench for rf_dump: a register-file array feeds the debug port and an
// ordered-word model (index sequence plus array contents) predicts every streamed word.
module tb_rf_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, out_ready;
    logic [4:0]  dbg_reg_ra;
    logic [31:0] dbg_reg_rd;
    logic        out_valid, out_last, busy, done;
    logic [31:0] out_data;
    logic [4:0]  out_idx;

    logic        start31, abort31, ready31;
    logic [4:0]  ra31;
    logic [31:0] rd31;
    logic        valid31, last31, busy31, done31;
    logic [31:0] data31;
    logic [4:0]  idx31;

    logic [31:0] rf [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign dbg_reg_rd = rf[dbg_reg_ra];
    assign rd31       = 32'hA500_0000 + {27'd0, ra31};

    rf_dump #(.FIRST_REG(0), .LAST_REG(31)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dbg_reg_ra(dbg_reg_ra), .dbg_reg_rd(dbg_reg_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    rf_dump #(.FIRST_REG(31), .LAST_REG(31)) u_dut31 (
        .clk(clk), .rst(rst), .start(start31), .abort(abort31),
        .dbg_reg_ra(ra31), .dbg_reg_rd(rd31),
        .out_valid(valid31), .out_ready(ready31), .out_data(data31),
        .out_idx(idx31), .out_last(last31), .busy(busy31), .done(done31)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until word idx is on the output; out_ready left as the caller set it.
    task automatic wait_idx(input int idx, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            tick();
            if (out_valid && (32'(out_idx) == idx)) ok = 1'b1;
        end
    endtask

    // mode 0: ready held high; 1: random ready + register-file writes;
    // 2: five-cycle stall on word 3; 3: extra start pulse while word 5 is shown.
    task automatic run_dump(input int mode, input int max_c);
        int          c, exp_idx, acc_c, n_acc, done_c, stall, extra;
        bit          in_word;
        logic [31:0] s_data;
        logic [4:0]  s_idx;
        logic        s_last;
        exp_idx = 0; acc_c = 0; n_acc = 0; done_c = -1; stall = 0; in_word = 1'b0;
        s_data = '0; s_idx = '0; s_last = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        chk("busy_after_start", 32'(busy), 1);
        chk("no_valid_in_fetch", 32'(out_valid), 0);
        while (c < max_c && done_c < 0) begin
            tick();
            c++;
            start = 1'b0;
            if (done) begin
                done_c = c;
                chk("done_cycle", c, acc_c + 1);
                chk("done_all_words", n_acc, 32);
                chk("done_no_valid", 32'(out_valid), 0);
            end
            chk("busy_in_dump", 32'(busy), 1);
            if (out_valid) begin
                if (!in_word) begin
                    chk("word_gap", c, acc_c + 2);
                    chk("word_idx", 32'(out_idx), exp_idx);
                    chk("word_data", out_data, rf[exp_idx & 31]);
                    chk("word_last", 32'(out_last), 32'(exp_idx == 31));
                    s_data = out_data; s_idx = out_idx; s_last = out_last;
                    in_word = 1'b1;
                    if (mode == 2 && exp_idx == 3) stall = 5;
                    if (mode == 3 && exp_idx == 5) start = 1'b1;
                end else begin
                    chk("hold_data", out_data, s_data);
                    chk("hold_idx", 32'(out_idx), 32'(s_idx));
                    chk("hold_last", 32'(out_last), 32'(s_last));
                end
                chk("ra_at_word", 32'(dbg_reg_ra), exp_idx);
                if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
                else if (stall > 0) begin out_ready = 1'b0; stall--; end
                else out_ready = 1'b1;
                if (out_ready) begin
                    in_word = 1'b0; acc_c = c; n_acc++; exp_idx++;
                end
                if (mode == 1 && $urandom_range(0, 1) == 1)
                    rf[$urandom_range(0, 31)] = $urandom;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", 32'(done_c > 0), 1);
        if (mode == 0) chk("done_at_65", done_c, 65);
        tick();
        chk("busy_fall", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done || busy || out_valid) extra++;
        end
        chk("idle_after_dump", extra, 0);
    endtask

    initial begin
        bit ok;
        int bad;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 + i;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start31 = 1'b0; abort31 = 1'b0; ready31 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_ra", 32'(dbg_reg_ra), 0);
        chk("rst_ra31", 32'(ra31), 31);
        rst = 1'b0;
        tick();
        chk("idle_no_start", 32'(busy), 0);

        // Single-register range.
        start31 = 1'b1;
        tick();
        start31 = 1'b0;
        chk("r31_busy", 32'(busy31), 1);
        tick();
        chk("r31_valid", 32'(valid31), 1);
        chk("r31_idx", 32'(idx31), 31);
        chk("r31_data", data31, 32'hA500_001F);
        chk("r31_last", 32'(last31), 1);
        tick();
        chk("r31_done", 32'(done31), 1);
        chk("r31_valid_clr", 32'(valid31), 0);
        tick();
        chk("r31_done_clr", 32'(done31), 0);
        chk("r31_busy_clr", 32'(busy31), 0);

        run_dump(0, 200);

        // Abort and start together in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", 32'(busy), 0);
        tick();
        chk("abort_start_idle2", 32'(busy), 0);

        // Abort while stalled in SEND at word 10.
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(10, ok);
        chk("abort_reach10", 32'(ok), 1);
        abort = 1'b1; out_ready = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ra", 32'(dbg_reg_ra), 0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done || busy) bad++;
        end
        chk("abort_no_done", bad, 0);

        // Abort in the same cycle as a handshake.
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(7, ok);
        chk("abort_hs_reach7", 32'(ok), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_hs_valid", 32'(out_valid), 0);
        chk("abort_hs_busy", 32'(busy), 0);
        chk("abort_hs_done", 32'(done), 0);

        run_dump(0, 200);
        run_dump(2, 300);
        run_dump(3, 300);
        for (int r = 0; r < 3; r++) run_dump(1, 600);

        // Asynchronous reset between edges during word 20.
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(20, ok);
        chk("rst_reach20", 32'(ok), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_data", out_data, 0);
        chk("arst_idx", 32'(out_idx), 0);
        chk("arst_ra", 32'(dbg_reg_ra), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (busy || out_valid || done) bad++;
        end
        chk("arst_stays_idle", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_dump.md
Name: rf_dump

Overview:
- Debug-side reader for the CPU register file.
- On a start pulse, it walks the register file's debug read port (dbg_reg_ra / dbg_reg_rd) from FIRST_REG to LAST_REG.
- It captures each word and streams it to a downstream consumer (PDU/UART formatter) over a valid/ready handshake.
- It sits between the register file's debug port and the debug/host output path, and never touches the write port.

Parameters:
- FIRST_REG, 0: first register index dumped (0..31).
- LAST_REG, 31: last register index dumped (FIRST_REG..31); FIRST_REG > LAST_REG is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel; highest priority after rst.
- dbg_reg_ra  output  5  register file debug read address.
- dbg_reg_rd  input  32  register file debug read data (combinational from dbg_reg_ra).
- out_valid  output  1  out_data/out_idx/out_last hold a word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  32  captured register value.
- out_idx  output  5  register index of out_data.
- out_last  output  1  current word is LAST_REG.
- busy  output  1  dump in progress (state != IDLE).
- done  output  1  one-cycle pulse when the final word is accepted.

Behaviour:
- One clock (clk). Reset is asynchronous, active-high (rst).
- All outputs are registered.
- Reset values:
  - state = IDLE, idx = FIRST_REG, dbg_reg_ra = FIRST_REG.
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0, done = 0.
- State machine: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 → idx ← FIRST_REG, dbg_reg_ra ← FIRST_REG, go to FETCH.
  - start=0 → stay.
- FETCH (one cycle):
  - dbg_reg_ra is already stable at idx.
  - Capture out_data ← dbg_reg_rd, out_idx ← idx, out_last ← (idx == LAST_REG), out_valid ← 1.
  - Go to SEND.
- SEND:
  - out_valid = 1. out_data, out_idx and out_last stay stable until accepted.
  - On out_ready=1:
    - Clear out_valid.
    - If out_last: go to DONE.
    - Else: idx ← idx+1, dbg_reg_ra ← idx+1, go to FETCH.
- DONE (one cycle):
  - done = 1, then go to IDLE.
  - idx and dbg_reg_ra return to FIRST_REG.
- busy = 1 in FETCH, SEND and DONE.
- Latency and throughput:
  - start sampled at edge N → FETCH in cycle N+1 → out_valid=1 from cycle N+2.
  - With out_ready held at 1: one word per 2 cycles.
  - Full 32-register dump: start to done pulse = 65 cycles.
- start outside IDLE is ignored; no queuing.
- Simultaneous start and abort in IDLE: abort wins, stay in IDLE.
- abort in any non-IDLE state → next cycle: IDLE, out_valid=0, busy=0, done=0, idx=FIRST_REG. No done pulse.
- abort in the same cycle as a handshake: the word counts as accepted by the consumer, but the FSM still goes to IDLE with no done pulse.
- rst mid-dump: immediate return to reset values regardless of the clock.
- Index arithmetic is 5-bit and never wraps: termination is by the out_last compare, so LAST_REG=31 never increments past 31.
- x0 is dumped like any other register (value as read, 0 in a correct register file).
- The block only reads dbg_reg_rd during FETCH. Register-file writes between words are reflected in later words; a word already captured is not updated.

Test Plan:
- Bench register-file model: dbg_reg_rd = 32'hA500_0000 + ra.
- Full dump, out_ready=1:
  - pulse start → out_valid first at cycle 2 with out_idx=0, out_data=32'hA5000000.
  - 32 words in order, idx 0..31; out_last only on idx 31 (out_data=32'hA500001F).
  - done pulse at cycle 65; busy falls the cycle after done.
- Backpressure:
  - hold out_ready=0 for 5 cycles at idx 3 → out_valid, out_idx=3 and out_data=32'hA5000003 stay stable.
  - dbg_reg_ra stays 3; raise out_ready → next word idx 4 two cycles later.
- Abort mid-dump:
  - assert abort while in SEND at idx 10 → next cycle out_valid=0, busy=0, no done pulse.
  - a new start then restarts at idx 0.
- start while busy: pulse start at idx 5 → ignored; sequence continues 6,7,…; exactly one done pulse.
- Async reset mid-dump: assert rst between edges during idx 20 → outputs go to reset values immediately, before the next clk edge; after release, idle until start.
- Parameter range FIRST_REG=31, LAST_REG=31: start → exactly one word, idx 31, out_last=1; done pulse 3 cycles after start.
